// File: rtl/machine_timer_pkg.sv
// Shared constants and types for the machine timer: register offsets, FSM
// encoding and the mtimecmp reset value.
package machine_timer_pkg;

  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;

  // All-ones keeps every hart quiet until software programs its compare value.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef logic [0:0] state_t;
  localparam state_t IDLE    = 1'b0;
  localparam state_t RESPOND = 1'b1;

endpackage

// File: rtl/machine_timer_comparator.sv
// One hart's mtimecmp register with 32-bit half-write decode and the
// registered "mtime >= mtimecmp" interrupt request.
module machine_timer_comparator
  import machine_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] mtime_i,
  output logic [63:0] mtimecmp_o,
  output logic        irq_o
);

  logic [63:0] cmp_q, cmp_d;
  logic        irq_q;

  always_comb begin
    cmp_d = cmp_q;
    if (wr_lo_i) cmp_d[31:0]  = wdata_i;
    if (wr_hi_i) cmp_d[63:32] = wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= MTIMECMP_RESET;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= (mtime_i >= cmp_q);
    end
  end

  assign mtimecmp_o = cmp_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: shared 64-bit mtime, per-hart mtimecmp and
// level interrupt requests. Optional prescaler under MACHINE_TIMER_PRESCALER_EN.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned NUM_HARTS   = 2,
  parameter int unsigned TICK_DIVIDE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_request_valid,
  output logic                 bus_request_ready,
  input  logic                 bus_write_enable,
  input  logic [15:0]          bus_address,
  input  logic [31:0]          bus_write_data,
  output logic                 bus_read_valid,
  output logic [31:0]          bus_read_data,
  output logic [NUM_HARTS-1:0] timer_interrupt_request
);

  if (NUM_HARTS < 1 || NUM_HARTS > 16) begin : g_bad_harts
    $error("machine_timer: NUM_HARTS must be 1..16");
  end
  if (TICK_DIVIDE < 1) begin : g_bad_divide
    $error("machine_timer: TICK_DIVIDE must be >= 1");
  end

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;
  logic        accept, wr, rd, tick;
  logic        mtime_lo_sel, mtime_hi_sel, mtime_wr;
  logic        cmp_hit;
  logic [3:0]  cmp_idx;
  logic [63:0] cmp_val [NUM_HARTS];
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_address[1:0];

  assign bus_request_ready = (state_q == IDLE);
  assign bus_read_valid    = (state_q == RESPOND);
  assign bus_read_data     = rdata_q;

  assign accept = bus_request_valid && bus_request_ready;
  assign wr     = accept && bus_write_enable;
  assign rd     = accept && !bus_write_enable;

  assign mtime_lo_sel = (bus_address[15:2] == MTIME_LO[15:2]);
  assign mtime_hi_sel = (bus_address[15:2] == MTIME_HI[15:2]);
  assign mtime_wr     = wr && (mtime_lo_sel || mtime_hi_sel);

  // The 0x4000..0x407F window holds up to 16 harts at 8 bytes each.
  assign cmp_idx = bus_address[6:3];
  assign cmp_hit = (bus_address[15:7] == MTIMECMP_BASE[15:7]) && (32'(cmp_idx) < NUM_HARTS);

`ifdef MACHINE_TIMER_PRESCALER_EN
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIVIDE - 1);

  logic [15:0] presc_q, presc_d;

  assign tick    = (presc_q == TICK_LAST);
  assign presc_d = (mtime_wr || tick) ? 16'd0 : presc_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= 16'd0;
    else        presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && mtime_lo_sel)      mtime_d[31:0]  = bus_write_data;
    else if (wr && mtime_hi_sel) mtime_d[63:32] = bus_write_data;
    else if (tick)               mtime_d        = mtime_q + 64'd1;
  end

  always_comb begin
    rd_mux = 32'd0;
    if (mtime_lo_sel)      rd_mux = mtime_q[31:0];
    else if (mtime_hi_sel) rd_mux = mtime_q[63:32];
    else if (cmp_hit) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (cmp_idx == 4'(h)) rd_mux = bus_address[2] ? cmp_val[h][63:32] : cmp_val[h][31:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (rd) begin
        state_d = RESPOND;
        rdata_d = rd_mux;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mtime_q <= 64'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      mtime_q <= mtime_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    machine_timer_comparator u_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_lo_i    (wr && cmp_hit && (cmp_idx == 4'(h)) && !bus_address[2]),
      .wr_hi_i    (wr && cmp_hit && (cmp_idx == 4'(h)) &&  bus_address[2]),
      .wdata_i    (bus_write_data),
      .mtime_i    (mtime_q),
      .mtimecmp_o (cmp_val[h]),
      .irq_o      (timer_interrupt_request[h])
    );
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped machine timer supplying per-hart `timer_interrupt_request` to each core's CSR file, where it appears as `mip.MTIP`. It holds one shared 64-bit `mtime` and one 64-bit `mtimecmp` per hart, and raises a hart's request while `mtime >= mtimecmp[h]`. It sits on the shared peripheral bus and is programmed by software through 32-bit word accesses.

## Interface
Parameters:
- `NUM_HARTS`, 2, number of harts and `mtimecmp` registers (1..16)
- `TICK_DIVIDE`, 4, clock cycles per `mtime` increment; used only under `MACHINE_TIMER_PRESCALER_EN` (≥1)

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `bus_request_valid`  in  1  request present
- `bus_request_ready`  out  1  block can accept a request
- `bus_write_enable`  in  1  1 = write, 0 = read
- `bus_address`  in  16  byte offset in block, word aligned
- `bus_write_data`  in  32  write data
- `bus_read_valid`  out  1  read data valid, one-cycle pulse
- `bus_read_data`  out  32  read data
- `timer_interrupt_request`  out  NUM_HARTS  per-hart pending timer interrupt

## Operation
- Register map:
  - `0x4000 + 8*h` is `mtimecmp[h]` low; `+4` is high.
  - `0xBFF8` is `mtime` low; `0xBFFC` is high.
  - Reads from unmapped addresses return 0; writes to them are ignored. `bus_address[1:0]` is ignored.
- Handshake FSM, states IDLE and RESPOND:
  - IDLE: `bus_request_ready=1`. A request is accepted when `valid && ready`.
  - Accepted write: stays IDLE and updates the register at that edge.
  - Accepted read: captures the data at that edge and moves to RESPOND.
  - RESPOND: `bus_read_valid=1`, `bus_read_data` = captured value, `ready=0`, then returns to IDLE. Reads therefore have a throughput of one per 2 cycles.
- `mtime`:
  - Increments by 1 every tick and wraps from 2^64−1 to 0.
  - A write to either half replaces only that half. In that cycle the write wins and no increment happens.
  - No carry is generated across a half-write.
- `mtimecmp[h]`: a half-write replaces only that half. Software writes the high half as 0xFFFFFFFF first to avoid a transient interrupt.
- Interrupt:
  - `timer_interrupt_request[h]` is registered: `irq[h] <= (mtime >= mtimecmp[h])`, using the unsigned 64-bit register values.
  - It is level-sensitive. It deasserts only when `mtimecmp` is raised above `mtime` or when `mtime` is written below `mtimecmp`.
- Read data is sampled from register values at the accept edge, before that edge's increment.

## Timing
- Reset values:
  - `mtime=0`, every `mtimecmp=0xFFFF_FFFF_FFFF_FFFF`, `irq=0`
  - FSM=IDLE, `bus_request_ready=1` (combinational from state), `bus_read_valid=0`, `bus_read_data=0`
- Read latency: accept at edge E, data valid in the cycle after E.
- Write visibility: the register holds the new value after edge E. `irq` reflects it after edge E+1.
- Compare latency: if the `mtime` register equals `mtimecmp[h]` during cycle T, `irq[h]` is high from cycle T+1.
- Reset mid-operation: if asserted during RESPOND, it drops `bus_read_valid` immediately (asynchronous reset). The read is lost and the master must not wait for it across reset.
- Simultaneous `mtime` write and increment: the write wins and the increment is dropped.

## Configuration
- `MACHINE_TIMER_PRESCALER_EN` defined:
  - A 16-bit prescale counter counts 0..TICK_DIVIDE−1 and wraps.
  - `mtime` increments only in the cycle the counter equals TICK_DIVIDE−1.
  - Any `mtime` write clears the counter to 0.
  - With TICK_DIVIDE=1, behaviour is identical to the undefined case.
- Undefined: no prescale counter. `mtime` increments every cycle and `TICK_DIVIDE` is unused.

## Structure
- Shared package `machine_timer_pkg` holds:
  - offsets `MTIMECMP_BASE=16'h4000`, `MTIME_LO=16'hBFF8`, `MTIME_HI=16'hBFFC`
  - the FSM state typedef (IDLE, RESPOND)
  - the `mtimecmp` reset constant
- One sub-module, `machine_timer_comparator`, instantiated NUM_HARTS times. It holds one `mtimecmp` with half-write decode, plus the registered compare output.

## Test plan
- Reset with no bus traffic for 100 cycles: `irq=0` throughout. Read of `0xBFF8` returns a value in 100..103. Read of `0xBFFC` returns 0.
- Write `mtimecmp[1]`: high=0, then low=50, with `mtime` near 0. `irq[1]` rises the cycle after `mtime==50`. `irq[0]` stays 0.
- With `irq[1]` high, write `0x400C`=0xFFFFFFFF. `irq[1]` falls 2 edges after the write accept.
- Write `mtime` high=0, low=0xFFFFFFFF; one tick later a read of high returns 1 and a read of low returns 0. Write high=low=0xFFFFFFFF; after one tick both read 0, confirming the wrap.
- Back-to-back reads with `valid` held high: `ready` alternates 1,0, and `bus_read_valid` pulses every second cycle. An unmapped read of `0x1000` returns 0. Reset asserted in RESPOND clears `bus_read_valid`.
- With `MACHINE_TIMER_PRESCALER_EN`, TICK_DIVIDE=4: `mtime` reads 25±1 after 100 cycles. Writing `mtime`=0 restarts a full 4-cycle tick period.
